// File: rtl/led_blink_pkg.sv
// Shared types and field widths for the LED channel blinker.
package led_blink_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   // Per-channel tap offset field width (offset 0..3)
   localparam int unsigned DIV_W    = 2;
   // Per-channel PWM duty field width (duty 0..15)
   localparam int unsigned DUTY_W   = 4;
   // Number of selectable tap bits above TAP
   localparam int unsigned TAP_SPAN = 1 << DIV_W;

endpackage

// File: rtl/led_blink_chan.sv
// One blinker channel: free-running counter, tap-bit mux, optional PWM
// gating and the registered LED drive. PWM gating is built only when
// LED_BLINK_PWM_EN is defined; otherwise duty is accepted and ignored.
module led_blink_chan
   import led_blink_pkg::*;
#(
   parameter int unsigned LEDS_PER_CH = 4,
   parameter int unsigned CNT_BITS    = 29,
   parameter int unsigned TAP         = 21
) (
   input  logic                   clk_1,
   input  logic                   rst,
   input  logic                   run,
   input  logic                   en,
   input  logic [DIV_W-1:0]       sel,
   input  logic [DUTY_W-1:0]      duty,
   output logic [LEDS_PER_CH-1:0] led
);

   logic [CNT_BITS-1:0] cnt;
   logic [TAP_SPAN-1:0] tap_bits;
   logic                tap;
   logic                led_val;

   assign tap_bits = cnt[TAP + TAP_SPAN - 1 : TAP];
   assign tap      = tap_bits[sel];

`ifdef LED_BLINK_PWM_EN
   assign led_val = tap & (cnt[DUTY_W-1:0] < duty);
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign led_val     = tap;
`endif

   // Counter advances only while running and enabled; otherwise holds
   always_ff @(posedge clk_1) begin
      if (!rst) begin
         cnt <= '0;
      end else if (run && en) begin
         cnt <= cnt + CNT_BITS'(1);
      end
   end

   // LED register: dark when disabled, follows tap while running, else frozen
   always_ff @(posedge clk_1) begin
      if (!rst) begin
         led <= '0;
      end else if (!en) begin
         led <= '0;
      end else if (run) begin
         led <= {LEDS_PER_CH{led_val}};
      end
   end

endmodule

// File: rtl/led_chan_blinker.sv
// Multi-channel LED blinker gated by a synchronised PLL lock flag.
// Optional feature macro: LED_BLINK_PWM_EN (per-channel PWM duty gating).
module led_chan_blinker
   import led_blink_pkg::*;
#(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned LEDS_PER_CH = 4,
   parameter int unsigned CNT_BITS    = 29,
   parameter int unsigned TAP         = 21,
   parameter int unsigned LOCK_WAIT   = 1024
) (
   input  logic                            clk_1,
   input  logic                            rst,
   input  logic                            pll_locked,
   input  logic [CHANNELS-1:0]             ch_en,
   input  logic [DIV_W*CHANNELS-1:0]       div_sel,
   input  logic [DUTY_W*CHANNELS-1:0]      duty,
   output logic [CHANNELS*LEDS_PER_CH-1:0] led,
   output logic                            running
);

   localparam int unsigned SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

   logic          lock_m;
   logic          lock_s;
   state_t        state_q;
   state_t        state_d;
   logic [SW-1:0] settle_q;
   logic [SW-1:0] settle_d;
   logic          run;

   // Lock synchroniser, FSM/settle registers and registered running flag
   always_ff @(posedge clk_1) begin
      if (!rst) begin
         lock_m   <= 1'b0;
         lock_s   <= 1'b0;
         state_q  <= WAIT_LOCK;
         settle_q <= '0;
         running  <= 1'b0;
      end else begin
         lock_m   <= pll_locked;
         lock_s   <= lock_m;
         state_q  <= state_d;
         settle_q <= settle_d;
         running  <= (state_d == RUN);
      end
   end

   // Next-state logic; loss of lock overrides everything else
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d  = SETTLE;
               settle_d = '0;
            end
         end
         SETTLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (settle_q == SW'(LOCK_WAIT - 1)) begin
               state_d = RUN;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase
   end

   assign run = (state_q == RUN);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      led_blink_chan #(
         .LEDS_PER_CH (LEDS_PER_CH),
         .CNT_BITS    (CNT_BITS),
         .TAP         (TAP)
      ) u_chan (
         .clk_1 (clk_1),
         .rst   (rst),
         .run   (run),
         .en    (ch_en[c]),
         .sel   (div_sel[c*DIV_W +: DIV_W]),
         .duty  (duty[c*DUTY_W +: DUTY_W]),
         .led   (led[c*LEDS_PER_CH +: LEDS_PER_CH])
      );
   end

endmodule

// File: tb/tb_led_chan_blinker.sv
// Bench for led_chan_blinker: per-cycle scoreboard plus directed checks.
module tb_led_chan_blinker;

   localparam int CH  = 2;
   localparam int LPC = 4;
   localparam int CB  = 8;
   localparam int TP  = 3;
   localparam int LW  = 4;

   logic              clk_1 = 1'b0;
   logic              rst;
   logic              pll_locked;
   logic [CH-1:0]     ch_en;
   logic [2*CH-1:0]   div_sel;
   logic [4*CH-1:0]   duty;
   logic [CH*LPC-1:0] led;
   logic              running;

   always #5 clk_1 = ~clk_1;

   led_chan_blinker #(
      .CHANNELS    (CH),
      .LEDS_PER_CH (LPC),
      .CNT_BITS    (CB),
      .TAP         (TP),
      .LOCK_WAIT   (LW)
   ) dut (
      .clk_1      (clk_1),
      .rst        (rst),
      .pll_locked (pll_locked),
      .ch_en      (ch_en),
      .div_sel    (div_sel),
      .duty       (duty),
      .led        (led),
      .running    (running)
   );

   typedef struct packed {
      logic [CH*LPC-1:0] led;
      logic              running;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state (0 = WAIT_LOCK, 1 = SETTLE, 2 = RUN)
   logic          m_lock_m, m_lock_s;
   int            m_state, m_settle;
   logic [CB-1:0] m_cnt [CH];
   logic          m_led [CH];

   function automatic logic tap_of(input logic [CB-1:0] c, input logic [1:0] s);
      logic [CB-1:0] sh;
      sh = c >> (TP + int'(s));
      return sh[0];
   endfunction

   // Advance the model by one clock edge using the currently driven inputs
   function automatic void model_step();
      exp_t e;
      int   old_st;
      logic old_ls;
      logic v;
      if (!rst) begin
         m_lock_m = 0; m_lock_s = 0; m_state = 0; m_settle = 0;
         for (int c = 0; c < CH; c++) begin m_cnt[c] = '0; m_led[c] = 0; end
      end else begin
         old_st = m_state;
         old_ls = m_lock_s;
         m_lock_s = m_lock_m;
         m_lock_m = pll_locked;
         case (old_st)
            0: if (old_ls) begin m_state = 1; m_settle = 0; end
            1: if (!old_ls) m_state = 0;
               else if (m_settle == LW - 1) m_state = 2;
               else m_settle = m_settle + 1;
            default: if (!old_ls) m_state = 0;
         endcase
         for (int c = 0; c < CH; c++) begin
            v = tap_of(m_cnt[c], div_sel[2*c +: 2]);
`ifdef LED_BLINK_PWM_EN
            v = v & (m_cnt[c][3:0] < duty[4*c +: 4]);
`endif
            if (!ch_en[c]) m_led[c] = 0;
            else if (old_st == 2) m_led[c] = v;
            if (old_st == 2 && ch_en[c]) m_cnt[c] = m_cnt[c] + 8'd1;
         end
      end
      e.running = (m_state == 2);
      for (int c = 0; c < CH; c++) e.led[c*LPC +: LPC] = {LPC{m_led[c]}};
      sb_q.push_back(e);
   endfunction

   // One clock: predict, clock, then pop and compare just after the edge
   task automatic step();
      exp_t e;
      model_step();
      @(posedge clk_1);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      assert (led === e.led) else begin
         n_fail++;
         $error("FAIL led observed=%h expected=%h", led, e.led);
      end
      n_checks++;
      assert (running === e.running) else begin
         n_fail++;
         $error("FAIL running observed=%b expected=%b", running, e.running);
      end
   endtask

   // Step until running rises; check it rises on exactly the expected edge
   task automatic wait_running(input string tag);
      int k;
      k = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (running === 1'b1) begin k = i; break; end
      end
      n_checks++;
      assert (k == 2 + LW) else begin
         n_fail++;
         $error("FAIL %s running_edge observed=%0d expected=%0d", tag, k, 2 + LW);
      end
   endtask

   initial begin
      int last0, last1, idx;
      logic p0, p1;

      rst = 0; pll_locked = 0; ch_en = '0; div_sel = '0; duty = '0;
      for (int i = 0; i < 3; i++) step();
      n_checks++;
      assert (led === '0 && running === 1'b0) else begin
         n_fail++;
         $error("FAIL reset_state observed=%h/%b expected=0/0", led, running);
      end

      // Lock sequence with both channels enabled, ch0 offset 0, ch1 offset 2
      rst = 1; pll_locked = 1; ch_en = 2'b11; div_sel = 4'b1000; duty = 8'hFF;
      wait_running("lock");

      // Toggle periods while running
      last0 = -1; last1 = -1; p0 = led[0]; p1 = led[LPC];
      for (idx = 0; idx < 300; idx++) begin
         step();
`ifndef LED_BLINK_PWM_EN
         if (led[0] !== p0) begin
            if (last0 >= 0) begin
               n_checks++;
               assert (idx - last0 == 8) else begin
                  n_fail++;
                  $error("FAIL ch0_period observed=%0d expected=8", idx - last0);
               end
            end
            last0 = idx;
         end
         if (led[LPC] !== p1) begin
            if (last1 >= 0) begin
               n_checks++;
               assert (idx - last1 == 32) else begin
                  n_fail++;
                  $error("FAIL ch1_period observed=%0d expected=32", idx - last1);
               end
            end
            last1 = idx;
         end
`endif
         p0 = led[0]; p1 = led[LPC];
      end

      // Disable ch0: dark on the next cycle, ch1 unaffected
      p1 = led[LPC];
      ch_en = 2'b10;
      step();
      n_checks++;
      assert (led[LPC-1:0] === '0) else begin
         n_fail++;
         $error("FAIL ch0_disable observed=%h expected=0", led[LPC-1:0]);
      end
      for (int i = 0; i < 5; i++) step();
      ch_en = 2'b11;
      for (int i = 0; i < 10; i++) step();

      // Lock loss: running drops within 3 cycles, then relock and settle again
      pll_locked = 0;
      idx = -1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (running === 1'b0) begin idx = i; break; end
      end
      n_checks++;
      assert (idx >= 0) else begin
         n_fail++;
         $error("FAIL lock_loss running observed=%b expected=0", running);
      end
      for (int i = 0; i < 8; i++) step();
      pll_locked = 1;
      wait_running("relock");

      // PWM region: ch0 on a slow tap with duty 4, then duty 0
      div_sel = 4'b1011; duty = 8'hF4;
      for (int i = 0; i < 150; i++) step();
      duty = 8'hF0;
      for (int i = 0; i < 100; i++) begin
         step();
`ifdef LED_BLINK_PWM_EN
         if (i > 0) begin
            n_checks++;
            assert (led[LPC-1:0] === '0) else begin
               n_fail++;
               $error("FAIL pwm_duty0 observed=%h expected=0", led[LPC-1:0]);
            end
         end
`endif
      end

      // Reset mid-run
      rst = 0;
      step();
      n_checks++;
      assert (led === '0 && running === 1'b0) else begin
         n_fail++;
         $error("FAIL midrun_reset observed=%h/%b expected=0/0", led, running);
      end
      rst = 1;
      wait_running("post_reset");
      for (int i = 0; i < 20; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/led_chan_blinker.md
LED_CHAN_BLINKER -- requirements
Module: led_chan_blinker

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent counter channels.
REQ-002 SHALL have parameter LEDS_PER_CH, default 4: LED outputs driven per channel.
REQ-003 SHALL have parameter CNT_BITS, default 29: counter width per channel.
REQ-004 SHALL have parameter TAP, default 21: base counter bit driving LEDs; TAP+3 < CNT_BITS.
REQ-005 SHALL have parameter LOCK_WAIT, default 1024: settle cycles after lock before counting; must be at least 1.
REQ-006 SHALL have port clk_1, input, 1: sole clock; reset rst, synchronous, active-low; clock clk_1.
REQ-007 SHALL have port rst, input, 1: synchronous active-low reset.
REQ-008 SHALL have port pll_locked, input, 1: asynchronous PLL lock flag.
REQ-009 SHALL have port ch_en, input, CHANNELS: per-channel count enable.
REQ-010 SHALL have port div_sel, input, 2*CHANNELS: per-channel tap offset 0..3.
REQ-011 SHALL have port duty, input, 4*CHANNELS: per-channel PWM duty 0..15.
REQ-012 SHALL have port led, output, CHANNELS*LEDS_PER_CH: channel c owns bits [c*LEDS_PER_CH +: LEDS_PER_CH].
REQ-013 SHALL have port running, output, 1: high while in state RUN.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer before use (lock_s).
REQ-015 Control FSM states SHALL be WAIT_LOCK, SETTLE and RUN.
REQ-016 FSM transitions SHALL be:
- WAIT_LOCK -> SETTLE when lock_s=1; the settle counter loads 0.
- SETTLE -> RUN when the settle counter reaches LOCK_WAIT-1 with lock_s=1.
- SETTLE or RUN -> WAIT_LOCK whenever lock_s=0, taking precedence over every other condition.
REQ-017 running SHALL be registered, high exactly in cycles whose state is RUN.
REQ-018 Channel counter c SHALL increment by 1 per cycle only when state is RUN and ch_en[c]=1; otherwise it holds its value (not cleared).
REQ-019 Counters SHALL wrap from 2^CNT_BITS-1 to 0 with no flag.
REQ-020 Tap bit for channel c SHALL be cnt_c[TAP + div_sel[c]]; a div_sel change SHALL take effect on the next registered LED update.
REQ-021 All LEDS_PER_CH bits of a channel SHALL carry the same value, registered with 1 cycle latency from the counter.
REQ-022 When ch_en[c]=0, channel c LEDs SHALL be forced 0 on the next cycle.
REQ-023 On lock loss, LEDs SHALL freeze at their last value and counters SHALL hold.

Reset
REQ-024 On rst=0 at a clk_1 edge, the following SHALL be cleared to 0:
- FSM (to WAIT_LOCK), settle counter and synchronizer flops.
- All channel counters.
- led and running.
REQ-025 Reset mid-RUN SHALL restart the full lock/settle sequence; no count SHALL occur in the reset cycle.

Configuration
REQ-026 Macro LED_BLINK_PWM_EN defined: each channel LED value SHALL be tap bit AND (cnt_c[3:0] < duty[c]); duty=0 forces the LED dark.
REQ-027 Macro LED_BLINK_PWM_EN undefined: the duty port SHALL remain present but be ignored; LEDs SHALL equal the tap bit.

Structure
REQ-028 A shared package led_blink_pkg SHALL hold the FSM state enum and the 2-bit/4-bit field width constants.
REQ-029 Sub-module led_blink_chan SHALL implement one channel (counter, tap mux, optional PWM, LED register) and be instantiated CHANNELS times via generate.

Verification (simulation parameters: CNT_BITS=8, TAP=3, LOCK_WAIT=4, CHANNELS=2)
REQ-030 Lock sequence: rst released, pll_locked=1 at cycle 0 -> running=1 no earlier than cycle 2+4 and stays 1; counters remain 0 beforehand.
REQ-031 Tap select: ch_en=2'b11, div_sel[0]=0, div_sel[1]=2 -> ch0 LEDs toggle every 8 cycles, ch1 LEDs every 32 cycles.
REQ-032 Wrap and enable: ch0 runs 256 cycles -> counter returns to 0; deasserting ch_en[0] -> ch0 LEDs 0 next cycle while ch1 is unaffected.
REQ-033 Lock loss: pll_locked drops in RUN -> running=0 within 3 cycles, counters hold; relock -> running resumes after LOCK_WAIT settle cycles.
REQ-034 PWM with LED_BLINK_PWM_EN: duty[0]=4 with tap bit high -> LED high 4 of every 16 cycles; duty[0]=0 -> LED always 0.
REQ-035 Reset mid-run: rst=0 for 1 cycle -> all counters, led and running read 0 on the next cycle.
